// File: rtl/flasher_sched_pkg.sv
// Shared types and helpers for the flasher scheduler slice.
// Optional watchdog is selected with FLASHER_SCHED_WDOG_EN in flasher_sched.
package flasher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        PULSE,
        WAIT_START,
        RUN,
        COOL
    } sched_state_t;

    localparam int LED_W_DEF = 16;

    // Width of a counter that must hold values 0..max_val.
    function automatic int timer_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/flasher_sched_if.sv
// Request/grant and flasher-monitor bundle between request sources, scheduler and flasher.
interface flasher_sched_if #(
    parameter int N_REQ = 4,
    parameter int LED_W = flasher_pkg::LED_W_DEF,
    parameter int CNT_W = 8
) ();

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic             flick;
    logic [LED_W-1:0] led_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] run_cnt;

    modport master (
        output req, led_in,
        input  grant, flick, busy, done, err, run_cnt
    );

    modport slave (
        input  req, led_in,
        output grant, flick, busy, done, err, run_cnt
    );

endinterface

// File: rtl/flasher_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % N_REQ);
            if (en_i && !found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flasher_sched.sv
// Round-robin scheduler sharing one bound-flasher between N_REQ requesters.
// Define FLASHER_SCHED_WDOG_EN to bound RUN length with a watchdog.
module flasher_sched
    import flasher_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int LED_W     = LED_W_DEF,
    parameter int QUIET_CYC = 4,
    parameter int START_TO  = 8,
    parameter int COOL_CYC  = 2,
    parameter int CNT_W     = 8,
    parameter int WDOG_CYC  = 1024
) (
    input logic            clk,
    input logic            rst_n,
    flasher_sched_if.slave bus
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int TMR_MAX = (START_TO > COOL_CYC) ? START_TO : COOL_CYC;
    localparam int TMR_W   = timer_w(TMR_MAX);
    localparam int QW      = timer_w(QUIET_CYC);

    if (N_REQ < 2 || N_REQ > 8 || QUIET_CYC < 2 || WDOG_CYC < 1) begin : g_param_check
        $error("flasher_sched: parameter out of range");
    end

    sched_state_t     state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [QW-1:0]    quiet_q, quiet_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             flick_q, flick_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0] arb_idx;
    logic             led_nz;

    assign led_nz = (bus.led_in != LED_W'(0));

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(PTR_W)) u_arb (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .en_i  (state_q == ARB),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

`ifdef FLASHER_SCHED_WDOG_EN
    localparam int WD_W = timer_w(WDOG_CYC);
    logic [WD_W-1:0] wdog_q, wdog_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            timer_q <= '0;
            quiet_q <= '0;
            grant_q <= '0;
            flick_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            quiet_q <= quiet_d;
            grant_q <= grant_d;
            flick_q <= flick_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        timer_d = (timer_q != '0) ? timer_q - TMR_W'(1) : '0;
        quiet_d = quiet_q;
        grant_d = '0;
        flick_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef FLASHER_SCHED_WDOG_EN
        wdog_d  = (wdog_q != '0) ? wdog_q - WD_W'(1) : '0;
`endif
        unique case (state_q)
            IDLE: if (bus.req != '0) state_d = ARB;
            ARB: begin
                if (arb_gnt != '0) begin
                    grant_d = arb_gnt;
                    ptr_d   = arb_idx;
                    state_d = PULSE;
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE: begin
                flick_d = 1'b1;
                timer_d = TMR_W'(START_TO);
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (led_nz) begin
                    quiet_d = '0;
                    state_d = RUN;
`ifdef FLASHER_SCHED_WDOG_EN
                    wdog_d  = WD_W'(WDOG_CYC);
`endif
                end else if (timer_q <= TMR_W'(1)) begin
                    err_d   = 1'b1;
                    timer_d = TMR_W'(COOL_CYC);
                    state_d = COOL;
                end
            end
            RUN: begin
                // Only QUIET_CYC consecutive dark samples end a run; shorter dips reset the count.
                if (led_nz) begin
                    quiet_d = '0;
                end else if (quiet_q >= QW'(QUIET_CYC - 1)) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    timer_d = TMR_W'(COOL_CYC);
                    state_d = COOL;
                end else begin
                    quiet_d = quiet_q + QW'(1);
                end
`ifdef FLASHER_SCHED_WDOG_EN
                if (wdog_q <= WD_W'(1)) begin
                    done_d  = 1'b0;
                    cnt_d   = cnt_q;
                    err_d   = 1'b1;
                    timer_d = TMR_W'(COOL_CYC);
                    state_d = COOL;
                end
`endif
            end
            COOL: if (timer_q <= TMR_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant   = grant_q;
    assign bus.flick   = flick_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.run_cnt = cnt_q;

endmodule

// File: tb/tb_flasher_sched.sv
// Self-checking bench for flasher_sched: directed scenarios plus randomized runs
// predicted by a behavioural model of request order and LED-run outcome.
`timescale 1ns/1ps
module tb_flasher_sched;

    localparam int N_REQ     = 4;
    localparam int LED_W     = 16;
    localparam int QUIET_CYC = 4;
    localparam int START_TO  = 8;
    localparam int COOL_CYC  = 2;
    localparam int CNT_W     = 8;
    localparam int WDOG_CYC  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N_REQ-1:0] req_v = '0;
    logic [LED_W-1:0] led_v = '0;

    flasher_sched_if #(.N_REQ(N_REQ), .LED_W(LED_W), .CNT_W(CNT_W)) bus ();

    assign bus.req    = req_v;
    assign bus.led_in = led_v;

    flasher_sched #(
        .N_REQ(N_REQ), .LED_W(LED_W), .QUIET_CYC(QUIET_CYC), .START_TO(START_TO),
        .COOL_CYC(COOL_CYC), .CNT_W(CNT_W), .WDOG_CYC(WDOG_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state
    int               exp_ptr = 0;
    int               exp_cnt = 0;
    logic             exp_err = 1'b0;
    bit               inject  = 1'b0;
    logic [LED_W-1:0] pat[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [LED_W-1:0] pat_at(input int j);
        return (j < pat.size()) ? pat[j] : '0;
    endfunction

    function automatic int pick_winner(input logic [N_REQ-1:0] r, input int p);
        for (int i = 1; i <= N_REQ; i++)
            if (r[(p + i) % N_REQ]) return (p + i) % N_REQ;
        return -1;
    endfunction

    // Outcome of a run: offset (in cycles after flick) of done or err.
    function automatic void predict(output bit is_err, output int off);
        int j0, zeros;
        j0 = -1;
        for (int j = 0; j < START_TO; j++)
            if (j0 < 0 && pat_at(j) != '0) j0 = j;
        if (j0 < 0) begin
            is_err = 1'b1;
            off    = START_TO;
            return;
        end
        is_err = 1'b0;
        zeros  = 0;
        off    = 0;
        for (int j = j0 + 1; off == 0; j++) begin
            if (pat_at(j) == '0) zeros++;
            else zeros = 0;
            if (zeros == QUIET_CYC) off = j + 1;
        end
`ifdef FLASHER_SCHED_WDOG_EN
        if (j0 + 1 + WDOG_CYC <= off) begin
            is_err = 1'b1;
            off    = j0 + 1 + WDOG_CYC;
        end
`endif
    endfunction

    task automatic make_pat(input int lead, input int len, input int dip);
        pat.delete();
        repeat (lead) pat.push_back('0);
        for (int i = 0; i < len; i++) pat.push_back(LED_W'($urandom_range(1, (1 << LED_W) - 1)));
        if (dip >= 0 && dip < len) pat[lead + dip] = '0;
    endtask

    task automatic make_rand_pat();
        int lead, len;
        lead = $urandom_range(0, 9);
        len  = $urandom_range(1, 12);
        pat.delete();
        repeat (lead) pat.push_back('0);
        for (int i = 0; i < len; i++)
            pat.push_back(($urandom_range(0, 3) == 0) ? '0 : LED_W'($urandom_range(1, (1 << LED_W) - 1)));
    endtask

    // One complete scheduled run; t_req >= 0 also checks the IDLE->grant latency,
    // abort_at > 0 asserts reset that many cycles after flick.
    task automatic run_one(input string tag, input int t_req, input int abort_at);
        int               exp_w, f_cyc, off, ev;
        bit               is_err, seen;
        logic [N_REQ-1:0] exp_g;
        exp_w = pick_winner(req_v, exp_ptr);
        exp_g = '0;
        if (exp_w >= 0) exp_g[exp_w] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            if (bus.grant !== '0) seen = 1'b1;
        end
        check({tag, " grant"}, bus.grant, exp_g);
        if (!seen || exp_w < 0) return;
        if (t_req >= 0) check({tag, " grant_latency"}, cyc - t_req, 2);
        check({tag, " flick_at_grant"}, bus.flick, 1'b0);
        exp_ptr      = exp_w;
        req_v[exp_w] = 1'b0;

        tick();
        check({tag, " flick_pulse"}, {bus.flick, bus.grant}, {1'b1, {N_REQ{1'b0}}});
        f_cyc = cyc;
        predict(is_err, off);
        ev    = f_cyc + off;
        led_v = pat_at(0);
        while (cyc < ev) begin
            tick();
            if (cyc < ev) begin
                check({tag, " in_run"}, {bus.flick, bus.done, bus.grant, bus.err, bus.busy},
                      {1'b0, 1'b0, {N_REQ{1'b0}}, exp_err, 1'b1});
                led_v = pat_at(cyc - f_cyc);
                if (inject && cyc - f_cyc == 2)
                    req_v = req_v | N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
                if (abort_at > 0 && cyc - f_cyc == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check({tag, " async_reset"},
                          {bus.flick, bus.busy, bus.grant, bus.done, bus.err, bus.run_cnt}, '0);
                    return;
                end
            end
        end
        if (is_err) exp_err = 1'b1;
        else exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        check({tag, " end_event"}, {bus.done, bus.err, bus.busy, bus.flick, bus.run_cnt},
              {~is_err, exp_err, 1'b1, 1'b0, CNT_W'(exp_cnt)});
        led_v = '0;
        for (int k = 1; k < COOL_CYC; k++) begin
            tick();
            check({tag, " cool"}, {bus.done, bus.busy, bus.flick, bus.grant},
                  {1'b0, 1'b1, 1'b0, {N_REQ{1'b0}}});
        end
        tick();
        check({tag, " back_idle"}, {bus.busy, bus.grant, bus.done}, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t;
        // Reset state
        repeat (3) tick();
        check("reset_outputs", {bus.grant, bus.flick, bus.busy, bus.done, bus.err, bus.run_cnt}, '0);
        rst_n = 1'b1;
        tick();

        // 1: single request, latency and one clean run
        req_v = 4'b0100;
        t     = cyc;
        pat.delete();
        pat.push_back('0); pat.push_back('0);
        pat.push_back(16'h0005); pat.push_back(16'h0006);
        pat.push_back(16'h0007); pat.push_back(16'h0008);
        run_one("single_req2", t, 0);

        // 2: all requesters pending, rotating grants
        req_v = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            make_pat(1, 5, -1);
            t = cyc;
            run_one($sformatf("all_req_run%0d", i), t, 0);
        end

        // Request withdrawn before arbitration
        req_v = 4'b0001;
        tick();
        check("drop_reached_arb", bus.busy, 1'b1);
        req_v = '0;
        tick();
        check("drop_no_grant", {bus.grant, bus.busy, bus.flick}, '0);
        tick();
        check("drop_stays_idle", {bus.grant, bus.busy}, '0);

        // 4: short dips inside a run
        req_v = 4'b0010;
        make_pat(0, 10, 4);
        run_one("dip_1cyc", cyc, 0);
        req_v = 4'b0100;
        pat.delete();
        repeat (3) pat.push_back(16'h00ff);
        repeat (QUIET_CYC - 1) pat.push_back('0);
        repeat (2) pat.push_back(16'h0f00);
        run_one("dip_3cyc", cyc, 0);

        // 6: long run, watchdog only in the macro build
        req_v = 4'b1000;
        make_pat(0, 40, -1);
        run_one("long_run", cyc, 0);

        // 3: LED never lights
        req_v = 4'b0001;
        pat.delete();
        run_one("start_timeout", cyc, 0);

        // Randomized runs with pending requests arriving mid-run
        inject = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (req_v == '0) req_v = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            make_rand_pat();
            run_one($sformatf("rand%0d", i), -1, 0);
        end
        inject = 1'b0;

        // 5: reset in the middle of a run, then normal service
        if (req_v == '0) req_v = 4'b0010;
        make_pat(0, 30, -1);
        run_one("reset_mid_run", -1, 6);
        exp_ptr = 0;
        exp_cnt = 0;
        exp_err = 1'b0;
        req_v   = '0;
        led_v   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("after_reset_idle", {bus.busy, bus.err, bus.run_cnt}, '0);
        req_v = 4'b1000;
        make_pat(2, 6, 3);
        run_one("post_reset", cyc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
